// File: rtl/reg_access_arbiter_if.sv
// rtl/reg_access_arbiter_if.sv - requester and register-port bundle for the register access arbiter
interface reg_access_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              iReq0;
   logic              iWe0;
   logic [DATA_W-1:0] iWData0;
   logic              oGnt0;
   logic              oDone0;
   logic              iReq1;
   logic              iWe1;
   logic [DATA_W-1:0] iWData1;
   logic              oGnt1;
   logic              oDone1;
   logic              oRegWrEn;
   logic [DATA_W-1:0] oRegWrData;
   logic [DATA_W-1:0] iRegRdData;
   logic [DATA_W-1:0] oRdData;
   logic              oBusy;

   modport slave (
      input  iReq0, iWe0, iWData0, iReq1, iWe1, iWData1, iRegRdData,
      output oGnt0, oDone0, oGnt1, oDone1, oRegWrEn, oRegWrData, oRdData, oBusy
   );

   modport master (
      output iReq0, iWe0, iWData0, iReq1, iWe1, iWData1, iRegRdData,
      input  oGnt0, oDone0, oGnt1, oDone1, oRegWrEn, oRegWrData, oRdData, oBusy
   );
endinterface

// File: rtl/reg_access_arbiter.sv
// rtl/reg_access_arbiter.sv - two-requester round-robin sequencer for a shared register port
module reg_access_arbiter #(
   parameter int DATA_W = 8
) (
   input  logic                 iClk,
   input  logic                 iRst,
   reg_access_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;
   logic   ptr_q, ptr_d;      // 0 favours requester 0 on a tie
   logic   access_q, access_d;
   logic   done_q, done_d;
   logic   gnt0_q, gnt0_d;
   logic   gnt1_q, gnt1_d;
   logic   done0_q, done0_d;
   logic   done1_q, done1_d;
   logic   busy_q, busy_d;

   logic              own_we;
   logic [DATA_W-1:0] own_wdata;

   // Next state, ownership and round-robin pointer; outputs decoded from the next state so they register cleanly
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.iReq0 && bus.iReq1) begin
               owner_d = ptr_q;
               state_d = S_ACCESS;
            end else if (bus.iReq0) begin
               owner_d = 1'b0;
               state_d = S_ACCESS;
            end else if (bus.iReq1) begin
               owner_d = 1'b1;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: state_d = S_DONE;
         S_DONE: begin
            ptr_d   = ~owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      access_d = (state_d == S_ACCESS);
      done_d   = (state_d == S_DONE);
      busy_d   = access_d || done_d;
      gnt0_d   = busy_d && !owner_d;
      gnt1_d   = busy_d && owner_d;
      done0_d  = done_d && !owner_d;
      done1_d  = done_d && owner_d;
   end

   // FSM state and registered status outputs; async reset clears everything at once
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         ptr_q    <= 1'b0;
         access_q <= 1'b0;
         done_q   <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         access_q <= access_d;
         done_q   <= done_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
      end
   end

   // Owner's op and data are steered combinationally so the write reflects the live bus during ACCESS
   always_comb begin
      own_we    = owner_q ? bus.iWe1    : bus.iWe0;
      own_wdata = owner_q ? bus.iWData1 : bus.iWData0;
   end

   assign bus.oGnt0      = gnt0_q;
   assign bus.oGnt1      = gnt1_q;
   assign bus.oDone0     = done0_q;
   assign bus.oDone1     = done1_q;
   assign bus.oBusy      = busy_q;
   assign bus.oRegWrEn   = access_q && own_we;
   assign bus.oRegWrData = (access_q && own_we) ? own_wdata : '0;
   // Register is sampled in DONE so a write reads back the value just stored
   assign bus.oRdData    = done_q ? bus.iRegRdData : '0;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb/tb_reg_access_arbiter.sv - self-checking bench for reg_access_arbiter
module tb_reg_access_arbiter;

   logic iClk = 1'b0;
   logic iRst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 1'b0;

   reg_access_arbiter_if #(.DATA_W(8)) bus ();

   reg_access_arbiter #(.DATA_W(8)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus.slave)
   );

   always #5 iClk = ~iClk;

   // Shared register the arbiter drives
   logic [7:0] breg = 8'h00;
   always @(posedge iClk) if (bus.oRegWrEn) breg <= bus.oRegWrData;
   assign bus.iRegRdData = breg;

   // Transaction-level model: a granted transaction lasts two cycles (left=2 access, left=1 done)
   int         m_left  = 0;
   bit         m_owner = 1'b0;
   bit         m_fav   = 1'b0;
   logic [7:0] m_reg   = 8'h00;

   always @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         m_left  <= 0;
         m_owner <= 1'b0;
         m_fav   <= 1'b0;
      end else if (m_left == 0) begin
         if (bus.iReq0 || bus.iReq1) begin
            m_owner <= (bus.iReq0 && bus.iReq1) ? m_fav : bus.iReq1;
            m_left  <= 2;
         end
      end else if (m_left == 2) begin
         if (m_owner ? bus.iWe1 : bus.iWe0) m_reg <= m_owner ? bus.iWData1 : bus.iWData0;
         m_left <= 1;
      end else begin
         m_fav  <= !m_owner;
         m_left <= 0;
      end
   end

   function automatic logic [21:0] act_vec();
      return {bus.oGnt0, bus.oGnt1, bus.oDone0, bus.oDone1, bus.oRegWrEn, bus.oBusy,
              bus.oRegWrData, bus.oRdData};
   endfunction

   function automatic logic [21:0] exp_vec();
      logic       g0, g1, d0, d1, we, busy;
      logic [7:0] wd, rd;
      logic       owe;
      owe  = m_owner ? bus.iWe1 : bus.iWe0;
      busy = (m_left != 0);
      g0   = busy && !m_owner;
      g1   = busy && m_owner;
      d0   = (m_left == 1) && !m_owner;
      d1   = (m_left == 1) && m_owner;
      we   = (m_left == 2) && owe;
      wd   = we ? (m_owner ? bus.iWData1 : bus.iWData0) : 8'h00;
      rd   = (m_left == 1) ? m_reg : 8'h00;
      return {g0, g1, d0, d1, we, busy, wd, rd};
   endfunction

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge iClk) begin
      if (cmp_en) begin
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, act_vec(), exp_vec());
         end
      end
   end

   // Grant order log (one entry per ACCESS cycle) and per-requester counters
   int q_gnt[$];
   int wren_cnt = 0, gnt0_cnt = 0, done0_cnt = 0, done1_cnt = 0;
   always @(negedge iClk) begin
      if (bus.oGnt0 && !bus.oDone0) q_gnt.push_back(0);
      if (bus.oGnt1 && !bus.oDone1) q_gnt.push_back(1);
      if (bus.oRegWrEn) wren_cnt++;
      if (bus.oGnt0) gnt0_cnt++;
      if (bus.oDone0) done0_cnt++;
      if (bus.oDone1) done1_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic clr_stats();
      q_gnt.delete();
      wren_cnt = 0; gnt0_cnt = 0; done0_cnt = 0; done1_cnt = 0;
   endtask

   task automatic requester(input bit r, input bit we, input logic [7:0] d, output bit ok);
      if (!r) begin bus.iReq0 = 1'b1; bus.iWe0 = we; bus.iWData0 = d; end
      else    begin bus.iReq1 = 1'b1; bus.iWe1 = we; bus.iWData1 = d; end
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if ((!r && bus.oDone0) || (r && bus.oDone1)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!r) bus.iReq0 = 1'b0; else bus.iReq1 = 1'b0;
   endtask

   bit ok0, ok1;
   int n;

   initial begin
      bus.iReq0 = 0; bus.iWe0 = 0; bus.iWData0 = 0;
      bus.iReq1 = 0; bus.iWe1 = 0; bus.iWData1 = 0;
      tick();
      chk("reset_outputs", {10'd0, act_vec()}, 32'd0);
      tick();
      iRst = 1'b0;
      cmp_en = 1'b1;

      // Requester 0 writes A5
      bus.iReq0 = 1; bus.iWe0 = 1; bus.iWData0 = 8'hA5;
      tick();
      chk("t1_access_gnt0", bus.oGnt0, 1);
      chk("t1_access_wren", bus.oRegWrEn, 1);
      chk("t1_access_wdata", bus.oRegWrData, 8'hA5);
      tick();
      chk("t1_done0", bus.oDone0, 1);
      chk("t1_rddata", bus.oRdData, 8'hA5);
      bus.iReq0 = 0;
      tick();
      chk("t1_idle_busy", bus.oBusy, 0);

      // Requester 1 reads back A5
      clr_stats();
      requester(1, 0, 8'h00, ok1);
      chk("t2_done_seen", ok1, 1);
      chk("t2_rddata", bus.oRdData, 8'hA5);
      chk("t2_wren_count", wren_cnt, 0);
      chk("t2_gnt0_count", gnt0_cnt, 0);
      tick();

      // Simultaneous writes from reset
      iRst = 1; tick(); iRst = 0;
      clr_stats();
      fork
         requester(0, 1, 8'h11, ok0);
         requester(1, 1, 8'h22, ok1);
      join
      tick();
      chk("t3_ok0", ok0, 1);
      chk("t3_ok1", ok1, 1);
      chk("t3_grants", q_gnt.size(), 2);
      if (q_gnt.size() == 2) begin
         chk("t3_first", q_gnt[0], 0);
         chk("t3_second", q_gnt[1], 1);
      end
      chk("t3_reg", breg, 8'h22);
      chk("t3_done0_count", done0_cnt, 1);
      chk("t3_done1_count", done1_cnt, 1);

      // Both held for four transactions
      clr_stats();
      bus.iReq0 = 1; bus.iWe0 = 1; bus.iWData0 = 8'h44;
      bus.iReq1 = 1; bus.iWe1 = 1; bus.iWData1 = 8'h55;
      n = 0;
      for (int i = 0; i < 30 && n < 4; i++) begin
         tick();
         if (bus.oDone0 || bus.oDone1) n++;
      end
      bus.iReq0 = 0; bus.iReq1 = 0;
      chk("t4_dones", n, 4);
      tick();
      chk("t4_grants", q_gnt.size(), 4);
      if (q_gnt.size() == 4) chk("t4_order", {q_gnt[0][7:0], q_gnt[1][7:0], q_gnt[2][7:0], q_gnt[3][7:0]}, 32'h00010001);
      chk("t4_reg", breg, 8'h55);

      // Leave the pointer favouring requester 1, then reset mid-write
      requester(0, 0, 8'h00, ok0);
      chk("t5_pre_read", ok0, 1);
      tick();
      bus.iReq0 = 1; bus.iWe0 = 1; bus.iWData0 = 8'h3C;
      tick();
      chk("t5_access_wren", bus.oRegWrEn, 1);
      #2 iRst = 1;
      #1 chk("t5_reset_outputs", {10'd0, act_vec()}, 32'd0);
      bus.iReq0 = 0;
      tick();
      iRst = 0;
      chk("t5_reg_kept", breg, 8'h55);
      clr_stats();
      fork
         requester(0, 0, 8'h00, ok0);
         requester(1, 0, 8'h00, ok1);
      join
      chk("t5_ok", {ok0, ok1}, 2'b11);
      chk("t5_grants", q_gnt.size(), 2);
      if (q_gnt.size() == 2) chk("t5_first_gnt", q_gnt[0], 0);
      tick();

      // Owner drops request during ACCESS
      bus.iReq1 = 1; bus.iWe1 = 1; bus.iWData1 = 8'h77;
      tick();
      chk("t6_access_gnt1", bus.oGnt1, 1);
      bus.iReq1 = 0;
      tick();
      chk("t6_done1", bus.oDone1, 1);
      chk("t6_rddata", bus.oRdData, 8'h77);
      tick();
      chk("t6_idle", bus.oBusy, 0);
      requester(0, 1, 8'h99, ok0);
      chk("t6_next_ok", ok0, 1);
      tick();
      chk("t6_reg", breg, 8'h99);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
